// File: rtl/cell_packet_tx_buffer.sv
// cell_packet_tx_buffer: store-and-forward session buffer from local BPM records to the cell-link TX stream
module cell_packet_tx_buffer #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] HEADER_TAG = 16'hA5BE
) (
    input  logic                  auroraUserClk,
    input  logic                  auroraUserReset,
    input  logic                  auroraFAstrobe,
    input  logic [31:0]           localBPMs_tdata,
    input  logic                  localBPMs_tvalid,
    input  logic                  localBPMs_tlast,
    output logic [31:0]           cellTX_tdata,
    output logic                  cellTX_tvalid,
    output logic                  cellTX_tlast,
    input  logic                  cellTX_tready,
    output logic [15:0]           sessionsSent,
    output logic [15:0]           sessionsDropped,
    output logic [1:0]            dropReason,
    output logic [ADDR_WIDTH:0]   fifoHighWater
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE = 1;

    typedef enum logic [1:0] {WAIT_START, ACCEPT, DISCARD} state_t;

    state_t        state, stateNext;
    logic [1:0]    wordIdx, wordIdxNext;
    logic [PW-1:0] wrPtr, wrPtrNext, commitPtr, commitPtrNext, rdPtr, fetchPtr, occAfterWrite;
    logic [32:0]   mem [0:(1<<ADDR_WIDTH)-1];
    logic          full, badFrame, doWrite, doDrop, doSent, loadOut;
    logic [1:0]    dropCode;

    assign full          = (wrPtr - rdPtr) == DEPTH;
    assign badFrame      = (wordIdx == 2'd0 && localBPMs_tdata[31:16] != HEADER_TAG) || (localBPMs_tlast && wordIdx != 2'd3);
    assign occAfterWrite = wrPtr + ONE - rdPtr;
    // the word presented on cellTX still occupies its slot, so fetch one past it
    assign fetchPtr      = cellTX_tvalid ? rdPtr + ONE : rdPtr;
    assign loadOut       = (!cellTX_tvalid || cellTX_tready) && fetchPtr != commitPtr;

    // input session FSM: the same-cycle word is handled first, then the strobe restarts the session
    always_comb begin
        stateNext     = state;
        wordIdxNext   = wordIdx;
        wrPtrNext     = wrPtr;
        commitPtrNext = commitPtr;
        doWrite       = 1'b0;
        doDrop        = 1'b0;
        doSent        = 1'b0;
        dropCode      = dropReason;
        if (state == ACCEPT && localBPMs_tvalid) begin
            if (full || badFrame) begin
                wrPtrNext = commitPtr;
                doDrop    = 1'b1;
                dropCode  = full ? 2'd1 : 2'd2;
                stateNext = DISCARD;
            end else begin
                doWrite     = 1'b1;
                wrPtrNext   = wrPtr + ONE;
                wordIdxNext = wordIdx + 2'd1;
                if (localBPMs_tlast) begin
                    commitPtrNext = wrPtr + ONE;
                    doSent        = 1'b1;
                    stateNext     = WAIT_START;
                end
            end
        end
        if (auroraFAstrobe) begin
            if (stateNext == ACCEPT && wrPtrNext != commitPtrNext) begin
                doDrop   = 1'b1;
                dropCode = 2'd3;
            end
            stateNext   = ACCEPT;
            wordIdxNext = 2'd0;
            wrPtrNext   = commitPtrNext;
        end
    end

    // input-side state and write/commit pointers
    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            state     <= WAIT_START;
            wordIdx   <= 2'd0;
            wrPtr     <= '0;
            commitPtr <= '0;
        end else begin
            state     <= stateNext;
            wordIdx   <= wordIdxNext;
            wrPtr     <= wrPtrNext;
            commitPtr <= commitPtrNext;
        end
    end

    // buffer RAM write port
    always_ff @(posedge auroraUserClk) begin
        if (doWrite) mem[wrPtr[ADDR_WIDTH-1:0]] <= {localBPMs_tlast, localBPMs_tdata};
    end

    // registered RAM read doubles as the cellTX output register; rdPtr advances on handshake
    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            rdPtr         <= '0;
            cellTX_tvalid <= 1'b0;
            cellTX_tlast  <= 1'b0;
            cellTX_tdata  <= '0;
        end else begin
            if (cellTX_tvalid && cellTX_tready) rdPtr <= rdPtr + ONE;
            if (!cellTX_tvalid || cellTX_tready) cellTX_tvalid <= fetchPtr != commitPtr;
            if (loadOut) {cellTX_tlast, cellTX_tdata} <= mem[fetchPtr[ADDR_WIDTH-1:0]];
        end
    end

    // saturating session counters, sticky drop cause and occupancy peak
    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            sessionsSent    <= '0;
            sessionsDropped <= '0;
            dropReason      <= 2'd0;
            fifoHighWater   <= '0;
        end else begin
            if (doSent && sessionsSent != 16'hFFFF) sessionsSent <= sessionsSent + 16'd1;
            if (doDrop && sessionsDropped != 16'hFFFF) sessionsDropped <= sessionsDropped + 16'd1;
            if (doDrop) dropReason <= dropCode;
            if (doWrite && occAfterWrite > fifoHighWater) fifoHighWater <= occAfterWrite;
        end
    end
endmodule

// File: tb/tb_cell_packet_tx_buffer.sv
// tb_cell_packet_tx_buffer: scoreboard bench for cell_packet_tx_buffer with directed sessions
module tb_cell_packet_tx_buffer;
    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [31:0] inData = '0;
    logic        inValid = 1'b0;
    logic        inLast = 1'b0;
    logic [31:0] txData;
    logic        txValid;
    logic        txLast;
    logic        txReady = 1'b1;
    logic [15:0] sent, dropped;
    logic [1:0]  reason;
    logic [AW:0] highWater;

    int          checks = 0;
    int          failures = 0;
    bit          toggleReady = 1'b0;
    logic [32:0] expQ[$];
    logic [31:0] sess[$];

    cell_packet_tx_buffer #(.ADDR_WIDTH(AW), .HEADER_TAG(16'hA5BE)) dut (
        .auroraUserClk(clk),
        .auroraUserReset(rst),
        .auroraFAstrobe(strobe),
        .localBPMs_tdata(inData),
        .localBPMs_tvalid(inValid),
        .localBPMs_tlast(inLast),
        .cellTX_tdata(txData),
        .cellTX_tvalid(txValid),
        .cellTX_tlast(txLast),
        .cellTX_tready(txReady),
        .sessionsSent(sent),
        .sessionsDropped(dropped),
        .dropReason(reason),
        .fifoHighWater(highWater)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every handshake and checks stall stability
    logic        prevStall = 1'b0;
    logic [32:0] prevWord = '0;
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) check("stall_hold", {txLast, txData}, prevWord);
            if (txValid && txReady) begin
                if (expQ.size() == 0) check("unexpected_word", {txLast, txData}, 33'h0_DEAD_BEEF ^ {txLast, txData} ^ {txLast, txData} ^ 33'h1);
                else check("tx_word", {txLast, txData}, expQ.pop_front());
            end
            prevStall = txValid && !txReady;
            prevWord  = {txLast, txData};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggleReady) txReady = ~txReady;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic doReset();
        rst = 1'b1;
        strobe = 1'b0;
        inValid = 1'b0;
        inLast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic s, input logic v, input logic [31:0] d, input logic l);
        strobe = s;
        inValid = v;
        inData = d;
        inLast = l;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        inValid = 1'b0;
        inLast = 1'b0;
    endtask

    task automatic build(input int nRec, input int badRec, input int seed);
        sess.delete();
        for (int r = 0; r < nRec; r++)
            for (int w = 0; w < 4; w++)
                sess.push_back(w == 0 ? {(r == badRec ? 16'h1234 : 16'hA5BE), 8'(seed), 8'(r)} : {8'(seed), 8'(r), 8'(w), 8'h5A});
    endtask

    task automatic sendSession(input int n, input bit withLast, input bit expectOut, input bit strobeLast);
        for (int i = 0; i < n; i++) begin
            if (expectOut) expQ.push_back({withLast && i == n - 1, sess[i]});
            drive(strobeLast && i == n - 1, 1'b1, sess[i], withLast && i == n - 1);
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("drained", 33'(expQ.size()), 33'd0);
    endtask

    initial begin
        // reset values
        doReset();
        @(negedge clk);
        check("rst_tvalid", 33'(txValid), 33'd0);
        check("rst_tdata", {txLast, txData}, 33'd0);
        check("rst_sent", 33'(sent), 33'd0);
        check("rst_dropped", 33'(dropped), 33'd0);
        check("rst_reason", 33'(reason), 33'd0);
        check("rst_highwater", 33'(highWater), 33'd0);

        // three good records, commit latency
        drive(1'b1, 1'b0, '0, 1'b0);
        build(3, -1, 1);
        sendSession(12, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("lat_n1_tvalid", 33'(txValid), 33'd0);
        @(negedge clk);
        check("lat_n2_tvalid", 33'(txValid), 33'd1);
        waitDrain();
        check("t1_sent", 33'(sent), 33'd1);
        check("t1_dropped", 33'(dropped), 33'd0);

        // same stream under alternating tready
        doReset();
        toggleReady = 1'b1;
        drive(1'b1, 1'b0, '0, 1'b0);
        build(3, -1, 2);
        sendSession(12, 1'b1, 1'b1, 1'b0);
        waitDrain();
        toggleReady = 1'b0;
        txReady = 1'b1;
        check("t2_sent", 33'(sent), 33'd1);

        // bad header in second record, then a clean session
        doReset();
        drive(1'b1, 1'b0, '0, 1'b0);
        build(3, 1, 3);
        sendSession(12, 1'b1, 1'b0, 1'b0);
        check("t3_dropped", 33'(dropped), 33'd1);
        check("t3_reason", 33'(reason), 33'd2);
        check("t3_sent0", 33'(sent), 33'd0);
        drive(1'b1, 1'b0, '0, 1'b0);
        build(2, -1, 4);
        sendSession(8, 1'b1, 1'b1, 1'b0);
        waitDrain();
        check("t3_sent1", 33'(sent), 33'd1);

        // abort after six words, then a complete eight-word session
        doReset();
        drive(1'b1, 1'b0, '0, 1'b0);
        build(2, -1, 5);
        sendSession(6, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        check("t4_reason", 33'(reason), 33'd3);
        check("t4_dropped", 33'(dropped), 33'd1);
        build(2, -1, 6);
        sendSession(8, 1'b1, 1'b1, 1'b0);
        waitDrain();
        check("t4_sent", 33'(sent), 33'd1);
        check("t4_dropped_after", 33'(dropped), 33'd1);

        // overflow: 4 committed words held, then a 16-word session overflows on word 13
        doReset();
        txReady = 1'b0;
        drive(1'b1, 1'b0, '0, 1'b0);
        build(1, -1, 7);
        sendSession(4, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        build(4, -1, 8);
        sendSession(16, 1'b1, 1'b0, 1'b0);
        check("t5_reason", 33'(reason), 33'd1);
        check("t5_dropped", 33'(dropped), 33'd1);
        check("t5_sent", 33'(sent), 33'd1);
        check("t5_highwater", 33'(highWater), 33'd16);
        txReady = 1'b1;
        waitDrain();

        // legal tlast coincident with strobe, next session starts immediately
        doReset();
        drive(1'b1, 1'b0, '0, 1'b0);
        build(1, -1, 9);
        sendSession(4, 1'b1, 1'b1, 1'b1);
        check("t6_sent", 33'(sent), 33'd1);
        check("t6_dropped", 33'(dropped), 33'd0);
        check("t6_reason", 33'(reason), 33'd0);
        build(1, -1, 10);
        sendSession(4, 1'b1, 1'b1, 1'b0);
        waitDrain();
        check("t6_sent2", 33'(sent), 33'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cell_packet_tx_buffer.md
# cell_packet_tx_buffer

Store-and-forward buffer between the local BPM readout stage and the cell-link Aurora TX stream. It accepts the local position-error stream: 4-word BPM records (header, X error, Y error, S), no backpressure, tlast on the final word of the session. It validates record framing and holds each session until it is complete. Only whole, well-formed sessions are released onto a backpressured AXI stream; malformed, overflowing or aborted sessions are rolled back and counted.

## Interface
- ADDR_WIDTH, 8: FIFO address width; depth = 2^ADDR_WIDTH 33-bit entries (data + last).
- HEADER_TAG, 16'hA5BE: required value of tdata[31:16] on the first word of every record.
- auroraUserClk  in  1  sole clock.
- auroraUserReset  in  1  reset, synchronous, active-high.
- auroraFAstrobe  in  1  start of transfer session; aborts any uncommitted session.
- localBPMs_tdata  in  32  record word.
- localBPMs_tvalid  in  1  word valid; no ready, so every valid word is consumed the cycle it appears.
- localBPMs_tlast  in  1  last word of session; qualified by tvalid.
- cellTX_tdata  out  32  outgoing word.
- cellTX_tvalid  out  1  outgoing valid.
- cellTX_tlast  out  1  last word of released session.
- cellTX_tready  in  1  downstream ready.
- sessionsSent  out  16  committed sessions; saturates at 16'hFFFF.
- sessionsDropped  out  16  discarded sessions; saturates at 16'hFFFF.
- dropReason  out  2  sticky cause of the most recent drop: 0 none, 1 overflow, 2 framing, 3 aborted.
- fifoHighWater  out  ADDR_WIDTH+1  peak occupancy since reset; occupancy includes uncommitted words.

## Operation
- Pointers: wrPtr (speculative write), commitPtr, rdPtr, each ADDR_WIDTH+1 bits and wrapping modulo 2^(ADDR_WIDTH+1).
  - Occupancy = wrPtr − rdPtr. Full when occupancy = 2^ADDR_WIDTH.
  - Committed data available when commitPtr ≠ rdPtr.
- Input state machine (states WAIT_START, ACCEPT, DISCARD):
  - WAIT_START: input words are ignored, with no counters touched.
  - Any state, auroraFAstrobe → ACCEPT, after the same-cycle word rule below. Clear wordIdx (2-bit, mod 4). Set wrPtr := commitPtr, rolling back any uncommitted words. If ACCEPT held ≥1 uncommitted word at the strobe: sessionsDropped++ and dropReason := 3.
  - ACCEPT, valid word, checks in order:
    - Full → overflow: rollback, sessionsDropped++, dropReason := 1, go to DISCARD.
    - wordIdx = 0 and tdata[31:16] ≠ HEADER_TAG, or tlast with wordIdx ≠ 3 → framing error: rollback, sessionsDropped++, dropReason := 2, go to DISCARD.
    - Otherwise write {tlast, tdata} at wrPtr, then wrPtr++ and wordIdx++.
    - If tlast: commitPtr := wrPtr+1, sessionsSent++, go to WAIT_START.
  - DISCARD: all words are ignored until the next auroraFAstrobe.
- Same-cycle word rule: a valid word in the same cycle as auroraFAstrobe belongs to the old session and is processed first.
  - If that word is a legal tlast, the session commits and the strobe aborts nothing.
  - The strobe then takes effect regardless.
- Rollback never discards committed words. It never affects a word already being presented on cellTX.
- Output: first-word-fall-through from a registered RAM read feeding a single output register.
  - cellTX_tdata/tlast are held stable while tvalid && !tready.
  - Only entries below commitPtr are ever read.
- Reset: pointers 0, state WAIT_START, wordIdx 0. Outputs cellTX_tvalid 0, cellTX_tlast 0, cellTX_tdata 0, sessionsSent 0, sessionsDropped 0, dropReason 0, fifoHighWater 0. Reset mid-session discards everything, including committed data.

## Timing
- Commit latency: input tlast accepted in cycle n → commitPtr updated at n+1 → cellTX_tvalid first high at n+2 when the FIFO was empty and tready was high.
- Throughput: one word per cycle out while tready = 1 and committed data remains; no bubbles between sessions.
- Counters and dropReason update the cycle after the causing event. fifoHighWater updates the cycle after a write.
- Simultaneous write and read at full: the full check uses occupancy from before the cycle, so a read in the same cycle does not rescue the write.

## Test plan
- Reset, strobe, 3 records (12 words, tags A5BE, tlast on word 12), tready = 1 → 12 identical words out, tlast on the 12th, first tvalid 2 cycles after input tlast, sessionsSent = 1.
- Same stream with tready toggling 1010… → data held stable while stalled, order preserved, no loss.
- Second record header 16'h1234 → nothing output, sessionsDropped = 1, dropReason = 2; the following session with correct tags passes.
- Strobe after 6 words without tlast → 0 words out, dropReason = 3; the following complete 8-word session is output intact.
- ADDR_WIDTH = 4, tready = 0, 4-word session committed, then an 16-word session → overflow on the 13th word, dropReason = 1, fifoHighWater = 16. After tready = 1, exactly the first 4 words emerge.
- Legal tlast word coincident with strobe → session committed (sessionsSent++), no drop, new session accepted next cycle.
